// File: rtl/multi_digit_switch_counter_pkg.sv
// multi_digit_switch_counter_pkg: BCD digit type and seven-segment patterns
package multi_digit_switch_counter_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  function automatic logic [6:0] seg_decode(input bcd_t d);
    return d == 4'd0 ? SEG_0 :
           d == 4'd1 ? SEG_1 :
           d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 :
           d == 4'd4 ? SEG_4 :
           d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 :
           d == 4'd7 ? SEG_7 :
           d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchroniser plus stability-counter debounce
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/multi_digit_switch_counter.sv
// multi_digit_switch_counter: debounced up/down BCD counter with seven-segment decode
module multi_digit_switch_counter
  import multi_digit_switch_counter_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_LEADING   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sliding_switch,
  input  logic                  clear_switch,
  input  logic                  dir_switch,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   encoded_count,
  output logic                  wrap
);
  logic slide_lvl, slide_prev, clear_lvl, count_event, carry, next_wrap, lead;
  logic [1:0] dir_sync;
  bcd_t [DIGITS-1:0] digits, next_digits;
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slide (
    .clk(clk), .reset(reset), .raw(sliding_switch), .level(slide_lvl)
  );
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .raw(clear_switch), .level(clear_lvl)
  );
  assign count_event = slide_prev & ~slide_lvl;
  assign count_bcd   = digits;
  always_comb begin
    next_digits = digits;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      next_digits[i] = !carry ? digits[i] :
                       dir_sync[1] ? (digits[i] == 4'd9 ? 4'd0 : digits[i] + 4'd1) :
                                     (digits[i] == 4'd0 ? 4'd9 : digits[i] - 4'd1);
      carry = carry & (digits[i] == (dir_sync[1] ? 4'd9 : 4'd0));
    end
    next_wrap = carry;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      digits     <= '0;
      wrap       <= 1'b0;
      slide_prev <= 1'b0;
      dir_sync   <= '0;
    end else begin
      dir_sync   <= {dir_sync[0], dir_switch};
      slide_prev <= slide_lvl;
      if (clear_lvl) begin
        digits <= '0;
        wrap   <= 1'b0;
      end else if (count_event) begin
        digits <= next_digits;
        wrap   <= next_wrap;
      end else wrap <= 1'b0;
    end
  end
  always_comb begin
    encoded_count = '0;
    lead = BLANK_LEADING != 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead & (digits[i] == 4'd0) & (i != 0);
      encoded_count[7*i +: 7] = lead ? SEG_BLANK : seg_decode(digits[i]);
    end
  end
endmodule

// File: tb/tb_multi_digit_switch_counter.sv
// tb_multi_digit_switch_counter: randomized scoreboard bench against a decimal reference model
module tb_multi_digit_switch_counter;
  typedef struct {
    int val;
    bit wrap;
    int cyc;
  } ev_t;
  logic clk = 1'b0, reset = 1'b1, sliding_switch = 1'b1, clear_switch = 1'b0, dir_switch = 1'b1;
  logic [7:0] count2;
  logic [13:0] enc2;
  logic wrap2;
  logic [15:0] count4;
  logic [27:0] enc4;
  logic wrap4;
  logic [7:0] prev2 = '0;
  logic [15:0] prev4 = '0;
  int cyc = 0, checks = 0, failures = 0, m2 = 0, m4 = 0;
  bit clear_on = 0, mon_on = 0;
  ev_t q2[$], q4[$];
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  multi_digit_switch_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(4), .BLANK_LEADING(0)) u_dut (
    .clk(clk), .reset(reset), .sliding_switch(sliding_switch), .clear_switch(clear_switch),
    .dir_switch(dir_switch), .count_bcd(count2), .encoded_count(enc2), .wrap(wrap2)
  );
  multi_digit_switch_counter #(.DIGITS(4), .DEBOUNCE_CYCLES(4), .BLANK_LEADING(1)) u_dut4 (
    .clk(clk), .reset(reset), .sliding_switch(sliding_switch), .clear_switch(clear_switch),
    .dir_switch(dir_switch), .count_bcd(count4), .encoded_count(enc4), .wrap(wrap4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] to_bcd(int v, int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic [63:0] to_seg(int v, int n, bit blank);
    logic [63:0] r = '0;
    int p = 1;
    for (int i = 0; i < n; i++) begin
      r[7*i +: 7] = (blank && i > 0 && v < p) ? 7'b1111111 : segtab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic count_ev(bit up, int t);
    ev_t e;
    if (clear_on) return;
    e.cyc = t;
    e.val = up ? (m2 + 1) % 100 : (m2 + 99) % 100;
    e.wrap = up ? (m2 == 99) : (m2 == 0);
    q2.push_back(e);
    m2 = e.val;
    e.val = up ? (m4 + 1) % 10000 : (m4 + 9999) % 10000;
    e.wrap = up ? (m4 == 9999) : (m4 == 0);
    q4.push_back(e);
    m4 = e.val;
  endtask
  task automatic force_zero(int t);
    ev_t e;
    e.val = 0;
    e.wrap = 0;
    e.cyc = t;
    if (m2 != 0) q2.push_back(e);
    if (m4 != 0) q4.push_back(e);
    m2 = 0;
    m4 = 0;
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(bit up0, bit up1, bit late, int bounces);
    dir_switch = up0;
    step(3);
    repeat (bounces) begin
      sliding_switch = 1'b0;
      step($urandom_range(1, 3));
      sliding_switch = 1'b1;
      step($urandom_range(1, 3));
    end
    sliding_switch = 1'b0;
    count_ev(late ? up1 : up0, cyc + 7);
    if (late) begin
      step(4);
      dir_switch = up1;
      step(6);
    end else step(10);
    sliding_switch = 1'b1;
    step(9);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (mon_on && (count2 !== prev2 || wrap2 !== 1'b0)) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d2_unexpected: count=%h wrap=%b at cycle %0d, expected no update", count2, wrap2, cyc);
      end else begin
        e = q2.pop_front();
        chk("d2_count", 64'(count2), to_bcd(e.val, 2));
        chk("d2_wrap", 64'(wrap2), 64'(e.wrap));
        chk("d2_enc", 64'(enc2), to_seg(e.val, 2, 0));
        chk("d2_time", 64'(cyc), 64'(e.cyc));
      end
    end
    prev2 <= count2;
  end
  always @(negedge clk) begin
    ev_t e;
    if (mon_on && (count4 !== prev4 || wrap4 !== 1'b0)) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d4_unexpected: count=%h wrap=%b at cycle %0d, expected no update", count4, wrap4, cyc);
      end else begin
        e = q4.pop_front();
        chk("d4_count", 64'(count4), to_bcd(e.val, 4));
        chk("d4_wrap", 64'(wrap4), 64'(e.wrap));
        chk("d4_enc", 64'(enc4), to_seg(e.val, 4, 1));
        chk("d4_time", 64'(cyc), 64'(e.cyc));
      end
    end
    prev4 <= count4;
  end
  initial begin
    step(3);
    reset = 1'b0;
    chk("reset_count2", 64'(count2), 64'(0));
    chk("reset_wrap2", 64'(wrap2), 64'(0));
    chk("reset_enc2", 64'(enc2), to_seg(0, 2, 0));
    chk("reset_count4", 64'(count4), 64'(0));
    chk("reset_enc4", 64'(enc4), to_seg(0, 4, 1));
    mon_on = 1;
    step(8);
    press(1, 1, 0, 0);
    press(1, 1, 0, 3);
    repeat (97) press(1, 1, 0, $urandom_range(0, 2));
    press(1, 1, 0, 0);
    press(0, 0, 0, 0);
    reset = 1'b1;
    force_zero(cyc + 1);
    step(1);
    reset = 1'b0;
    step(8);
    repeat (42) press(1, 1, 0, $urandom_range(0, 3));
    sliding_switch = 1'b0;
    clear_switch = 1'b1;
    force_zero(cyc + 7);
    clear_on = 1;
    step(10);
    sliding_switch = 1'b1;
    step(9);
    repeat (3) press(1'($urandom_range(0, 1)), 1, 0, $urandom_range(0, 3));
    clear_switch = 1'b0;
    step(12);
    clear_on = 0;
    repeat (40) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
    sliding_switch = 1'b0;
    step(4);
    reset = 1'b1;
    force_zero(cyc + 1);
    step(1);
    reset = 1'b0;
    step(10);
    sliding_switch = 1'b1;
    step(10);
    press(0, 0, 0, 0);
    press(1, 1, 0, 1);
    step(20);
    chk("q2_drained", 64'(q2.size()), 64'(0));
    chk("q4_drained", 64'(q4.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_digit_switch_counter.md
MULTI_DIGIT_SWITCH_COUNTER -- requirements
Module: multi_digit_switch_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of BCD digits, legal range 1..8.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: required input stability in clocks, legal minimum 1.
REQ-003 The block SHALL have parameter BLANK_LEADING, default 0: when 1, leading-zero digits are blanked.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 The block SHALL have port sliding_switch, input, 1 bit: raw asynchronous count switch.
REQ-007 The block SHALL have port clear_switch, input, 1 bit: raw asynchronous clear; level 1 requests clear.
REQ-008 The block SHALL have port dir_switch, input, 1 bit: raw asynchronous direction; 1 = up, 0 = down.
REQ-009 The block SHALL have port count_bcd, output, 4*DIGITS bits: registered count; digit 0 (least significant) in bits [3:0].
REQ-010 The block SHALL have port encoded_count, output, 7*DIGITS bits: active-low segments, bit order gfedcba per digit; digit 0 in bits [6:0].
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle registered pulse on wrap-around.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchroniser.
REQ-013 sliding_switch and clear_switch SHALL each be debounced: the debounced level changes only after the synchronised level differs from it on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the stability counter at 0.
REQ-014 dir_switch SHALL be synchronised only, not debounced.
REQ-015 A 1-to-0 transition of debounced sliding_switch SHALL produce exactly one count event; a 0-to-1 transition SHALL produce none.
REQ-016 On a count event, count_bcd SHALL update on the next edge: +1 if synchronised dir = 1, -1 if dir = 0, in decimal with per-digit carry/borrow.
REQ-017 Latency: with the raw switch held low from the first edge that samples it low, count_bcd SHALL change on exactly the (3 + DEBOUNCE_CYCLES)-th edge counted from that edge.
REQ-018 Up from all-9s SHALL give all-0s, and down from all-0s SHALL give all-9s; wrap SHALL be 1 on the same edge as that update and 0 on all other cycles.
REQ-019 While debounced clear = 1, count_bcd SHALL be held at 0 and count events SHALL be discarded; clear SHALL take priority when clear and a count event coincide.
REQ-020 wrap SHALL NOT assert on a clear.
REQ-021 encoded_count SHALL be a combinational decode of count_bcd, adding no latency: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 With BLANK_LEADING = 1, every zero digit above the most significant non-zero digit SHALL output 1111111; digit 0 SHALL never be blanked.
REQ-023 Debounce SHALL be sampled continuously; a count event and a dir change in the same cycle SHALL use the synchronised dir value of that cycle.

Reset
REQ-024 Reset SHALL clear count_bcd to 0, wrap to 0, and all synchroniser flops, debounced levels and stability counters to 0.
REQ-025 Reset asserted mid-debounce SHALL discard the pending transition.
REQ-026 A switch already high at reset release SHALL produce no count event; only its later fall SHALL count.

Structure
REQ-027 A shared package SHALL hold the seven-segment pattern constants, the blank constant and the BCD digit type.
REQ-028 One sub-module, switch_debouncer, SHALL contain the synchroniser and debounce logic; it SHALL be parameterised by DEBOUNCE_CYCLES and instantiated twice.
REQ-029 The stability counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DIGITS=2, DEBOUNCE_CYCLES=4 unless stated)
REQ-030 Reset, then a clean sliding_switch 1->0 with dir=1: count_bcd = 0x01 exactly 7 edges after the first low sample; encoded_count = {1000000,1111001}.
REQ-031 A bounce of 3-cycle low pulses separated by high cycles, then a steady low: exactly one increment.
REQ-032 Preload 99 by 99 presses, then 1 more press with dir=1: count 00 and a one-cycle wrap; then a press with dir=0: count 99 and a one-cycle wrap.
REQ-033 Debounced clear coincident with a count event at count 42: count 00, wrap 0; further presses while clear is held: count stays 00.
REQ-034 DIGITS=4, BLANK_LEADING=1, count 0007: digits 3..1 = 1111111 and digit 0 = 1111000; count 0000: only digit 0 shows 1000000.
REQ-035 Reset asserted 2 cycles into a debounce window: no count change; debounced level 0; wrap 0.
